// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: forwarding selects, load-use stall, branch flush and halt drain FSM.
// Optional operand forwarding is enabled by defining FORWARD_EN; without it every RAW hazard stalls.
module hazard_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        uses_rs1_d,
  input  logic        uses_rs2_d,
  input  logic        pause_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic        writesreg_e,
  input  logic        memtoreg_e,
  input  logic        brtaken_e,
  input  logic [4:0]  rd_m,
  input  logic        writesreg_m,
  input  logic [4:0]  rd_w,
  input  logic        writesreg_w,
  input  logic        resume,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic [1:0]  fwda_e,
  output logic [1:0]  fwdb_e,
  output logic        halted,
  output logic [15:0] stall_count,
  output logic [1:0]  o_state_dbg
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_drain_cnt;
  logic [1:0]  w_drain_nxt;
  logic [15:0] r_stall_cnt;
  logic        w_cnt_inc;
  logic        w_hit_e;
  logic        w_lu;

  // x0 is hardwired to zero, so it never participates in a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  assign w_hit_e = writesreg_e &
                   ((uses_rs1_d & reg_match(rd_e, rs1_d)) |
                    (uses_rs2_d & reg_match(rd_e, rs2_d)));

`ifdef FORWARD_EN
  assign w_lu = memtoreg_e & w_hit_e;

  always_comb begin
    fwda_e = 2'b00;
    if (writesreg_m && reg_match(rd_m, rs1_e))      fwda_e = 2'b10;
    else if (writesreg_w && reg_match(rd_w, rs1_e)) fwda_e = 2'b01;
  end

  always_comb begin
    fwdb_e = 2'b00;
    if (writesreg_m && reg_match(rd_m, rs2_e))      fwdb_e = 2'b10;
    else if (writesreg_w && reg_match(rd_w, rs2_e)) fwdb_e = 2'b01;
  end
`else
  logic w_hit_m;
  logic w_unused_nofwd;

  // No bypass paths: any pending E or M write to a used source must stall.
  assign w_hit_m = writesreg_m &
                   ((uses_rs1_d & reg_match(rd_m, rs1_d)) |
                    (uses_rs2_d & reg_match(rd_m, rs2_d)));
  assign w_lu           = w_hit_e | w_hit_m;
  assign fwda_e         = 2'b00;
  assign fwdb_e         = 2'b00;
  assign w_unused_nofwd = ^{rs1_e, rs2_e, rd_w, writesreg_w, memtoreg_e};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    w_cnt_inc   = 1'b0;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      RUN: begin
        // A taken branch squashes the younger instructions, so their hazards and halts are moot.
        if (brtaken_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (w_lu) begin
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          flush_e   = 1'b1;
          w_cnt_inc = 1'b1;
        end else if (pause_d) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = 2'd3;
        end
      end
      DRAIN: begin
        stall_f     = 1'b1;
        flush_d     = 1'b1;
        w_drain_nxt = r_drain_cnt - 2'd1;
        if (r_drain_cnt <= 2'd1) begin
          w_state_nxt = HALTED;
          w_drain_nxt = 2'd0;
        end
      end
      HALTED: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
        halted  = 1'b1;
        if (resume) w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
        w_drain_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_drain_cnt <= 2'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_cnt_inc && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: vector table for the combinational hazard/forward paths,
// plus hand sequences for halt drain, resume and reset during drain. Honours FORWARD_EN.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        uses_rs1_d, uses_rs2_d, pause_d;
  logic        writesreg_e, memtoreg_e, brtaken_e, writesreg_m, writesreg_w, resume;
  logic        stall_f, stall_d, flush_d, flush_e, halted;
  logic [1:0]  fwda_e, fwdb_e, o_state_dbg;
  logic [15:0] stall_count;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  localparam logic [1:0] ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALTED = 2'd2;

  hazard_sequencer dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
    .pause_d(pause_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .writesreg_e(writesreg_e), .memtoreg_e(memtoreg_e), .brtaken_e(brtaken_e),
    .rd_m(rd_m), .writesreg_m(writesreg_m), .rd_w(rd_w), .writesreg_w(writesreg_w),
    .resume(resume),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwda_e(fwda_e), .fwdb_e(fwdb_e), .halted(halted), .stall_count(stall_count),
    .o_state_dbg(o_state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1_d, rs2_d;
    logic       u1, u2, pause;
    logic [4:0] rs1_e, rs2_e, rd_e;
    logic       we, me, br;
    logic [4:0] rd_m;
    logic       wm;
    logic [4:0] rd_w;
    logic       ww;
    logic       stl_nf, stl_f;
    logic [1:0] fa_f, fb_f;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; uses_rs1_d = 0; uses_rs2_d = 0; pause_d = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0; writesreg_e = 0; memtoreg_e = 0; brtaken_e = 0;
    rd_m = 0; writesreg_m = 0; rd_w = 0; writesreg_w = 0; resume = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic sf, input logic sd, input logic fd,
                          input logic fe, input logic h);
    chk({tag, ".stall_f"}, {15'd0, stall_f}, {15'd0, sf});
    chk({tag, ".stall_d"}, {15'd0, stall_d}, {15'd0, sd});
    chk({tag, ".flush_d"}, {15'd0, flush_d}, {15'd0, fd});
    chk({tag, ".flush_e"}, {15'd0, flush_e}, {15'd0, fe});
    chk({tag, ".halted"},  {15'd0, halted},  {15'd0, h});
  endtask

  initial begin
    logic       stl;
    logic [1:0] efa, efb;

    //        rs1d rs2d u1 u2 pa rs1e rs2e rde we me br rdm wm rdw ww nf f  fa     fb
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vt[1]  = '{0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 5, 1, 5, 1, 0, 0, 2'b10, 2'b00};
    vt[2]  = '{0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 2'b01, 2'b00};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 2'b00, 2'b01};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00};
    vt[5]  = '{0, 3, 0, 1, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00};
    vt[6]  = '{0, 3, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vt[7]  = '{0, 3, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vt[8]  = '{6, 0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00};
    vt[9]  = '{4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00};
    vt[10] = '{9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 2'b00, 2'b00};
    vt[11] = '{3, 0, 1, 0, 1, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00};
    vt[12] = '{0, 0, 0, 0, 0, 8, 8, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 2'b10, 2'b10};
    vt[13] = '{0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vt[14] = '{0, 3, 0, 1, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vt[15] = '{1, 2, 1, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00};

    // Reset state
    idle();
    reset = 1'b1;
    tick();
    chk("rst.state", {14'd0, o_state_dbg}, {14'd0, ST_RUN});
    chk("rst.count", stall_count, 16'd0);
    chk_outs("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Single-cycle vectors, all applied in RUN
    for (int i = 0; i < 16; i++) begin
      rs1_d = vt[i].rs1_d; rs2_d = vt[i].rs2_d; uses_rs1_d = vt[i].u1; uses_rs2_d = vt[i].u2;
      pause_d = vt[i].pause; rs1_e = vt[i].rs1_e; rs2_e = vt[i].rs2_e; rd_e = vt[i].rd_e;
      writesreg_e = vt[i].we; memtoreg_e = vt[i].me; brtaken_e = vt[i].br;
      rd_m = vt[i].rd_m; writesreg_m = vt[i].wm; rd_w = vt[i].rd_w; writesreg_w = vt[i].ww;
`ifdef FORWARD_EN
      stl = vt[i].stl_f; efa = vt[i].fa_f; efb = vt[i].fb_f;
`else
      stl = vt[i].stl_nf; efa = 2'b00; efb = 2'b00;
`endif
      #2;
      chk_outs($sformatf("vec%0d", i), !vt[i].br && stl, !vt[i].br && stl, vt[i].br,
               vt[i].br || stl, 1'b0);
      chk($sformatf("vec%0d.fwda", i), {14'd0, fwda_e}, {14'd0, efa});
      chk($sformatf("vec%0d.fwdb", i), {14'd0, fwdb_e}, {14'd0, efb});
      if (!vt[i].br && stl && exp_cnt != 16'hFFFF) exp_cnt++;
      tick();
      chk($sformatf("vec%0d.count", i), stall_count, exp_cnt);
      chk($sformatf("vec%0d.state", i), {14'd0, o_state_dbg}, {14'd0, ST_RUN});
    end

    // Halt: three DRAIN cycles (resume ignored), then HALTED until resume
    idle();
    pause_d = 1'b1;
    #2;
    chk_outs("pause", 0, 0, 0, 0, 0);
    tick();
    pause_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resume = (i == 1);
      #2;
      chk($sformatf("drain%0d.state", i), {14'd0, o_state_dbg}, {14'd0, ST_DRAIN});
      chk_outs($sformatf("drain%0d", i), 1, 0, 1, 0, 0);
      tick();
    end
    resume = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk($sformatf("halt%0d.state", i), {14'd0, o_state_dbg}, {14'd0, ST_HALTED});
      chk_outs($sformatf("halt%0d", i), 1, 1, 0, 1, 1);
      tick();
    end
    resume = 1'b1;
    #2;
    chk_outs("resume_req", 1, 1, 0, 1, 1);
    tick();
    resume = 1'b0;
    #2;
    chk("resumed.state", {14'd0, o_state_dbg}, {14'd0, ST_RUN});
    chk_outs("resumed", 0, 0, 0, 0, 0);
    chk("resumed.count", stall_count, exp_cnt);
    tick();

    // Reset during the second DRAIN cycle
    pause_d = 1'b1;
    tick();
    pause_d = 1'b0;
    tick();
    chk("drain2.state", {14'd0, o_state_dbg}, {14'd0, ST_DRAIN});
    #2;
    reset = 1'b1;
    #1;
    exp_cnt = 16'd0;
    chk("midrst.state", {14'd0, o_state_dbg}, {14'd0, ST_RUN});
    chk("midrst.count", stall_count, exp_cnt);
    chk_outs("midrst", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("postrst.state", {14'd0, o_state_dbg}, {14'd0, ST_RUN});
    chk_outs("postrst", 0, 0, 0, 0, 0);

    // Count restarts after reset
    rd_e = 5'd3; writesreg_e = 1'b1; memtoreg_e = 1'b1; rs2_d = 5'd3; uses_rs2_d = 1'b1;
    tick();
    idle();
    #2;
    chk("recount", stall_count, 16'd1);
    chk_outs("recount", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 rs1_d, rs2_d  in  5 each  decode-stage source register numbers.
REQ-005 uses_rs1_d, uses_rs2_d  in  1 each  decode instruction reads rs1/rs2.
REQ-006 pause_d  in  1  decode instruction is a halt (decoder pause).
REQ-007 rs1_e, rs2_e, rd_e  in  5 each  execute-stage source and destination registers.
REQ-008 writesreg_e, memtoreg_e, brtaken_e  in  1 each  execute writes a register; execute is a load; branch or jump taken.
REQ-009 rd_m, writesreg_m  in  5, 1  memory-stage destination and write enable.
REQ-010 rd_w, writesreg_w  in  5, 1  writeback-stage destination and write enable.
REQ-011 resume  in  1  restart request while halted.
REQ-012 stall_f, stall_d  out  1 each  hold the fetch and decode registers.
REQ-013 flush_d, flush_e  out  1 each  load a bubble into the decode and execute registers.
REQ-014 fwda_e, fwdb_e  out  2 each  ALU operand source: 00 register file, 10 M result, 01 W result.
REQ-015 halted  out  1  core halted.
REQ-016 stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-017 Register x0 SHALL never match in any hazard or forwarding compare.
REQ-018 Forwarding SHALL be combinational: fwda_e=10 if writesreg_m and rd_m==rs1_e; else 01 if writesreg_w and rd_w==rs1_e; else 00. fwdb_e uses the same rule with rs2_e.
REQ-019 Load-use hazard lu SHALL be memtoreg_e & writesreg_e & rd_e matches a used decode source.
REQ-020 The register file is write-through, so a W-stage destination SHALL never cause a stall.
REQ-021 The FSM states SHALL be RUN, DRAIN and HALTED.
REQ-022 In RUN with brtaken_e: flush_d=1, flush_e=1, no stall; a concurrent lu or pause_d SHALL be ignored.
REQ-023 In RUN with lu and no brtaken_e: stall_f=1, stall_d=1, flush_e=1; stall_count increments and saturates at 0xFFFF.
REQ-024 In RUN with pause_d, no lu and no brtaken_e: the next state SHALL be DRAIN with a 2-bit drain counter loaded to 3.
REQ-025 In DRAIN: stall_f=1 and flush_d=1; the counter decrements each cycle, and the state moves to HALTED when it reaches 0 (three DRAIN cycles).
REQ-026 In HALTED: stall_f=1, stall_d=1, flush_e=1, halted=1.
REQ-027 In HALTED with resume: the next state SHALL be RUN; resume SHALL be ignored in every other state.
REQ-028 Outputs SHALL be 0 in RUN when no condition applies.

Reset
REQ-029 Reset SHALL force state RUN, drain counter 0 and stall_count 0; all registered outputs SHALL be 0, including mid-DRAIN and while HALTED.

Configuration
REQ-030 With FORWARD_EN defined, the block SHALL forward per REQ-018 and stall only per REQ-019.
REQ-031 Without FORWARD_EN, fwda_e and fwdb_e SHALL be 00.
REQ-032 Without FORWARD_EN, lu SHALL extend to any used decode source matching rd_e (writesreg_e) or rd_m (writesreg_m), with the stall behaviour of REQ-023.

Verification
REQ-033 With FORWARD_EN: rd_m=5, writesreg_m=1, rd_w=5, writesreg_w=1, rs1_e=5 -> fwda_e=10; with rd_m=0 instead -> fwda_e=01.
REQ-034 Load x3 in E, rs2_d=3, uses_rs2_d=1 -> one cycle of stall_f=stall_d=flush_e=1 and stall_count=1; the same case with rd_e=0 -> no stall.
REQ-035 brtaken_e=1 with lu and pause_d both set -> flush_d=flush_e=1, stall_f=0, and state remains RUN.
REQ-036 pause_d=1 -> three DRAIN cycles, then halted=1; resume=1 -> halted=0 next cycle, and resume during DRAIN has no effect.
REQ-037 Reset asserted in the second DRAIN cycle -> all outputs 0 immediately and state RUN.
REQ-038 Without FORWARD_EN: rd_m=4, writesreg_m=1, rs1_d=4, uses_rs1_d=1 -> stall asserted, fwda_e=00.
